// File: rtl/zeroriscy_multdiv_seq_if.sv
// Request/response bundle of the sequential multiplier/divider.
// The master drives the operation; the slave returns status and result.
interface zeroriscy_multdiv_seq_if;
    logic        en_i;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;

    modport master (
        output en_i, operator_i, op_a_i, op_b_i, kill_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  en_i, operator_i, op_a_i, op_b_i, kill_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/zeroriscy_multdiv_seq.sv
// Unsigned 32-bit shift-add multiplier and restoring divider, one bit
// per cycle, borrowing the ALU's extended adder for all arithmetic.
module zeroriscy_multdiv_seq (
    input  logic                          clk,
    input  logic                          rst,
    zeroriscy_multdiv_seq_if.slave        bus,
    output logic                          alu_en_o,
    output logic [32:0]                   alu_operand_a_o,
    output logic [32:0]                   alu_operand_b_o,
    input  logic [33:0]                   alu_adder_ext_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    op_e         op_q, op_d;
    logic [31:0] m_q, m_d;
    logic [31:0] d_q, d_d;
    logic [63:0] p_q, p_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;

    logic [32:0] s;
    logic        ok;
    logic        valid;
    logic [31:0] result;
    logic        unused_adder_lsb;

    // The adder LSB only ever sums the two injected carry bits.
    assign unused_adder_lsb = alu_adder_ext_i[0];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        op_d            = op_q;
        m_d             = m_q;
        d_d             = d_q;
        p_d             = p_q;
        r_d             = r_q;
        q_d             = q_q;
        alu_en_o        = 1'b0;
        alu_operand_a_o = 33'b0;
        alu_operand_b_o = 33'b0;
        valid           = 1'b0;
        result          = 32'b0;
        s               = {r_q, q_q[31]};
        ok              = alu_adder_ext_i[33] | s[32];

        unique case (state_q)
            IDLE: begin
                if (bus.en_i && !bus.kill_i) begin
                    state_d = ITER;
                    cnt_d   = 5'd31;
                    op_d    = op_e'(bus.operator_i);
                    m_d     = bus.op_a_i;
                    d_d     = bus.op_b_i;
                    p_d     = {32'b0, bus.op_b_i};
                    r_d     = 32'b0;
                    q_d     = bus.op_a_i;
                end
            end
            ITER: begin
                alu_en_o = 1'b1;
                if (!op_q[1]) begin
                    alu_operand_a_o = {p_q[63:32], 1'b0};
                    alu_operand_b_o = {(p_q[0] ? m_q : 32'b0), 1'b0};
                    p_d = {alu_adder_ext_i[33:1], p_q[31:1]};
                end else begin
                    // Carry-in via the LSBs turns A + ~D into S - D.
                    alu_operand_a_o = {s[31:0], 1'b1};
                    alu_operand_b_o = {~d_q, 1'b1};
                    r_d = ok ? alu_adder_ext_i[32:1] : s[31:0];
                    q_d = {q_q[30:0], ok};
                end
                if (cnt_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
                if (bus.kill_i) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid   = !bus.kill_i;
                if (valid) begin
                    unique case (op_q)
                        OP_MUL:   result = p_q[31:0];
                        OP_MULHU: result = p_q[63:32];
                        OP_DIVU:  result = q_q;
                        OP_REMU:  result = r_q;
                        default:  result = 32'b0;
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= OP_MUL;
            m_q     <= 32'b0;
            d_q     <= 32'b0;
            p_q     <= 64'b0;
            r_q     <= 32'b0;
            q_q     <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            m_q     <= m_d;
            d_q     <= d_d;
            p_q     <= p_d;
            r_q     <= r_d;
            q_q     <= q_d;
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.valid_o  = valid;
    assign bus.result_o = result;

endmodule

// File: tb/tb_zeroriscy_multdiv_seq.sv
// Directed bench for the sequential multiplier/divider with an
// ideal adder standing in for the ALU.
module tb_zeroriscy_multdiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_en;
    logic [32:0] alu_a;
    logic [32:0] alu_b;
    logic [33:0] alu_sum;
    int          tests = 0;
    int          fails = 0;

    zeroriscy_multdiv_seq_if bus ();

    zeroriscy_multdiv_seq dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .alu_en_o        (alu_en),
        .alu_operand_a_o (alu_a),
        .alu_operand_b_o (alu_b),
        .alu_adder_ext_i (alu_sum)
    );

    always #5 clk = ~clk;

    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " ready"}, 64'(bus.ready_o), 64'd1);
        chk({tag, " valid"}, 64'(bus.valid_o), 64'd0);
        chk({tag, " alu_en"}, 64'(alu_en), 64'd0);
        chk({tag, " alu_a"}, 64'(alu_a), 64'd0);
        chk({tag, " alu_b"}, 64'(alu_b), 64'd0);
        chk({tag, " result"}, 64'(bus.result_o), 64'd0);
    endtask

    // Called at a negedge while the DUT is idle; that cycle is cycle 0.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input bit hold, input string tag);
        bus.en_i       = 1'b1;
        bus.operator_i = op;
        bus.op_a_i     = a;
        bus.op_b_i     = b;
        chk({tag, " ready c0"}, 64'(bus.ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.en_i       = hold;
        bus.operator_i = 2'($urandom);
        bus.op_a_i     = $urandom;
        bus.op_b_i     = $urandom;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk($sformatf("%s valid c%0d", tag, k),
                64'(bus.valid_o), 64'(k == 33));
            chk($sformatf("%s alu_en c%0d", tag, k),
                64'(alu_en), 64'(k <= 32));
            chk($sformatf("%s ready c%0d", tag, k),
                64'(bus.ready_o), 64'd0);
            chk($sformatf("%s result c%0d", tag, k),
                64'(bus.result_o), (k == 33) ? 64'(exp) : 64'd0);
        end
        @(negedge clk);
        chk({tag, " ready c34"}, 64'(bus.ready_o), 64'd1);
        chk({tag, " valid c34"}, 64'(bus.valid_o), 64'd0);
    endtask

    task automatic watch(input int n, input string tag);
        int c = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.valid_o) c++;
        end
        chk(tag, 64'(c), 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.en_i       = 1'b0;
        bus.kill_i     = 1'b0;
        bus.operator_i = 2'b00;
        bus.op_a_i     = 32'b0;
        bus.op_b_i     = 32'b0;
        #1;
        idle_chk("reset t0");
        bus.en_i = 1'b1;
        repeat (2) @(negedge clk);
        idle_chk("reset held en");
        bus.en_i = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        idle_chk("post reset");

        run_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b0, "mul 7x6");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0,
               "mulhu ff");
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0,
               "mul ff");
        run_op(2'b10, 32'd100, 32'd7, 32'd14, 1'b0, "divu 100/7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, "remu 100/7");
        run_op(2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 1'b0,
               "divu big");
        run_op(2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0,
               "remu big");
        run_op(2'b10, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1'b0, "divu /0");
        run_op(2'b11, 32'h12345678, 32'd0, 32'h12345678, 1'b0, "remu /0");

        // Kill in the middle of ITER.
        bus.en_i       = 1'b1;
        bus.operator_i = 2'b00;
        bus.op_a_i     = 32'd9;
        bus.op_b_i     = 32'd9;
        @(posedge clk);
        #1 bus.en_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("kill iter alu_en", 64'(alu_en), 64'd1);
        bus.kill_i = 1'b1;
        #1 chk("kill iter valid", 64'(bus.valid_o), 64'd0);
        @(posedge clk);
        #1 bus.kill_i = 1'b0;
        @(negedge clk);
        idle_chk("kill iter next");
        watch(40, "kill iter no valid");
        run_op(2'b00, 32'd3, 32'd5, 32'd15, 1'b0, "mul 3x5");

        // Kill in DONE suppresses the strobe combinationally.
        bus.en_i       = 1'b1;
        bus.operator_i = 2'b10;
        bus.op_a_i     = 32'd100;
        bus.op_b_i     = 32'd7;
        @(posedge clk);
        #1 bus.en_i = 1'b0;
        repeat (33) @(negedge clk);
        chk("kill done alu_en", 64'(alu_en), 64'd0);
        chk("kill done ready", 64'(bus.ready_o), 64'd0);
        bus.kill_i = 1'b1;
        #1;
        chk("kill done valid", 64'(bus.valid_o), 64'd0);
        chk("kill done result", 64'(bus.result_o), 64'd0);
        @(posedge clk);
        #1 bus.kill_i = 1'b0;
        @(negedge clk);
        idle_chk("kill done next");

        // Kill together with en in IDLE must not start.
        bus.en_i   = 1'b1;
        bus.kill_i = 1'b1;
        @(posedge clk);
        #1;
        bus.en_i   = 1'b0;
        bus.kill_i = 1'b0;
        @(negedge clk);
        idle_chk("kill+en idle");
        watch(40, "kill+en no valid");

        // Reset in the middle of a divide.
        bus.en_i       = 1'b1;
        bus.operator_i = 2'b10;
        bus.op_a_i     = 32'hFFFFFFFF;
        bus.op_b_i     = 32'd3;
        @(posedge clk);
        #1 bus.en_i = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1 idle_chk("rst mid");
        @(posedge clk);
        #1 idle_chk("rst mid edge");
        @(negedge clk);
        rst = 1'b0;
        watch(40, "rst no valid");
        run_op(2'b11, 32'd10, 32'd3, 32'd1, 1'b0, "remu 10/3");

        // en held high across DONE restarts at cycle 34.
        run_op(2'b10, 32'd1000, 32'd10, 32'd100, 1'b1, "divu hold");
        run_op(2'b01, 32'h00010000, 32'h00010000, 32'd1, 1'b0,
               "mulhu b2b");
        watch(40, "b2b no extra valid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
